// File: rtl/fixed_point_alu_seq.sv
// Handshaked signed Q-format add/sub/mul/div with iterative restoring divide.
// Build option: define FXP_ALU_SAT_EN to saturate on overflow / divide-by-zero (default wraps).
//
// state  | meaning
// S_IDLE | ready for a new operand pair, in_ready high
// S_EXEC | computing; single cycle except for divide (N+Q iterations)
// S_DONE | result presented, waiting for out_ready
module fixed_point_alu_seq #(
  parameter int N = 32,
  parameter int Q = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         dz
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] LIM_POS = {{(Q+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [W-1:0] LIM_NEG = {{Q{1'b0}}, 1'b1, {(N-1){1'b0}}};
`ifdef FXP_ALU_SAT_EN
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_a, r_b, r_bmag, r_rem, r_result;
  logic [1:0]     r_op;
  logic [W-1:0]   r_quo;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf, r_dz;

  logic           w_accept, w_is_div, w_bz, w_exec_done;
  logic [N-1:0]   w_a_abs, w_b_abs;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_prod;
  logic signed [2*N-1:0] w_prod_sh;
  logic           w_mul_ovf;
  logic [N:0]     w_rem_sh;
  logic           w_ge;
  logic [N-1:0]   w_rem_sub, w_rem_next;
  logic [W-1:0]   w_quo_next;
  logic           w_q_neg, w_q_ovf;
  logic [N-1:0]   w_q_low, w_q_wrap;
  logic [N-1:0]   w_wrap, w_res;
  logic           w_ovf, w_dz;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_is_div    = (r_op == 2'b11);
  assign w_bz        = (r_b == '0);
  assign w_exec_done = (r_state == S_EXEC) && (!w_is_div || w_bz || (r_cnt == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)    w_state_next = S_EXEC;
      S_EXEC:  if (w_exec_done) w_state_next = S_DONE;
      S_DONE:  if (out_ready)   w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  assign w_a_abs = a[N-1] ? -a : a;
  assign w_b_abs = b[N-1] ? -b : b;

  assign w_sum = r_op[0] ? ({r_a[N-1], r_a} - {r_b[N-1], r_b})
                         : ({r_a[N-1], r_a} + {r_b[N-1], r_b});

  // Sign-extended operands make the low 2N bits of the unsigned product the signed product.
  assign w_prod    = {{N{r_a[N-1]}}, r_a} * {{N{r_b[N-1]}}, r_b};
  assign w_prod_sh = $signed(w_prod) >>> Q;
  assign w_mul_ovf = !((&w_prod_sh[2*N-1:N-1]) || (~|w_prod_sh[2*N-1:N-1]));

  // Dividend bits leave r_quo at the top while quotient bits enter at the bottom.
  assign w_rem_sh   = {r_rem, r_quo[W-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_bmag});
  assign w_rem_sub  = w_rem_sh[N-1:0] - r_bmag;
  assign w_rem_next = w_ge ? w_rem_sub : w_rem_sh[N-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_ge};
  assign w_q_neg    = r_a[N-1] ^ r_b[N-1];
  assign w_q_ovf    = (w_quo_next > (w_q_neg ? LIM_NEG : LIM_POS));
  assign w_q_low    = w_quo_next[N-1:0];
  assign w_q_wrap   = w_q_neg ? -w_q_low : w_q_low;

  always_comb begin
    w_ovf  = 1'b0;
    w_dz   = 1'b0;
    w_wrap = '0;
    case (r_op)
      2'b10: begin
        w_ovf  = w_mul_ovf;
        w_wrap = w_prod_sh[N-1:0];
      end
      2'b11: begin
        if (w_bz) begin
          w_dz = 1'b1;
        end else begin
          w_ovf  = w_q_ovf;
          w_wrap = w_q_wrap;
        end
      end
      default: begin
        w_ovf  = w_sum[N] ^ w_sum[N-1];
        w_wrap = w_sum[N-1:0];
      end
    endcase
  end

`ifdef FXP_ALU_SAT_EN
  logic w_pos;

  always_comb begin
    case (r_op)
      2'b10:   w_pos = !w_prod_sh[2*N-1];
      2'b11:   w_pos = !w_q_neg;
      default: w_pos = !w_sum[N];
    endcase
  end

  always_comb begin
    if (w_dz)       w_res = r_a[N-1] ? MIN_NEG : MAX_POS;
    else if (w_ovf) w_res = w_pos ? MAX_POS : MIN_NEG;
    else            w_res = w_wrap;
  end
`else
  assign w_res = w_dz ? '0 : w_wrap;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_bmag   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_bmag <= w_b_abs;
      r_quo  <= {w_a_abs, {Q{1'b0}}};
      r_rem  <= '0;
      r_cnt  <= CW'(W - 1);
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (w_exec_done) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_dz     <= w_dz;
      end else begin
        r_quo <= w_quo_next;
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign result = r_result;
  assign ovf    = r_ovf;
  assign dz     = r_dz;

endmodule

// File: tb/tb_fixed_point_alu_seq.sv
// Bench for fixed_point_alu_seq (N=32, Q=20): directed vectors, back-pressure,
// mid-divide reset and randomized operations against an arithmetic reference model.
module tb_fixed_point_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = '0;
  logic        in_ready, out_valid, ovf, dz;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;
`ifdef FXP_ALU_SAT_EN
  localparam logic [31:0] DZ_POS_RES = 32'h7fffffff;
  localparam logic [31:0] OVF_ADD_RES = 32'h7fffffff;
`else
  localparam logic [31:0] DZ_POS_RES = 32'h00000000;
  localparam logic [31:0] OVF_ADD_RES = 32'h80000000;
`endif

  always #5 clk = ~clk;

  fixed_point_alu_seq #(.N(32), .Q(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .dz        (dz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-number rules on 64-bit integers, then range check.
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                                output logic [31:0] r, output logic ov, output logic dzo);
    longint sa, sb, t, mag;
    logic [63:0] tv;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    t = 0;
    ov = 1'b0;
    dzo = 1'b0;
    case (iop)
      2'd0: t = sa + sb;
      2'd1: t = sa - sb;
      2'd2: t = (sa * sb) >>> 20;
      default: begin
        if (sb == 0) dzo = 1'b1;
        else begin
          mag = ((sa < 0 ? -sa : sa) <<< 20) / (sb < 0 ? -sb : sb);
          t = ((sa < 0) != (sb < 0)) ? -mag : mag;
        end
      end
    endcase
    if (dzo) begin
`ifdef FXP_ALU_SAT_EN
      r = (sa >= 0) ? 32'h7fffffff : 32'h80000000;
`else
      r = 32'h0;
`endif
    end else begin
      ov = (t > MAXV) || (t < MINV);
      tv = t;
      r = tv[31:0];
`ifdef FXP_ALU_SAT_EN
      if (ov) r = (t > 0) ? 32'h7fffffff : 32'h80000000;
`endif
    end
  endfunction

  // Issues one operation; returns with the result visible (#1 after the edge that raised out_valid).
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop, output int lat);
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic dir(input string tag, input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                     input logic [31:0] er, input logic eo, input logic ed, input int el);
    int lat;
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    run_op(ia, ib, iop, lat);
    chk({tag, ".latency"}, lat, el);
    chk({tag, ".result"}, result, er);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".dz"}, dz, ed);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_clr"}, out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] ra, rb, er, held;
    logic [1:0]  rop;
    logic        eo, ed;
    int          mode;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", result, 32'h0);
    chk("rst.ovf", ovf, 1'b0);
    chk("rst.dz", dz, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    dir("mul_ref", 32'hffffe000, 32'h00002000, 2'b10, 32'hffffffc0, 1'b0, 1'b0, 1);
    dir("add",     32'h00180000, 32'h00080000, 2'b00, 32'h00200000, 1'b0, 1'b0, 1);
    dir("sub",     32'h00180000, 32'h00080000, 2'b01, 32'h00100000, 1'b0, 1'b0, 1);
    dir("div_pos", 32'h00300000, 32'h00200000, 2'b11, 32'h00180000, 1'b0, 1'b0, 52);
    dir("div_neg", 32'hffd00000, 32'h00200000, 2'b11, 32'hffe80000, 1'b0, 1'b0, 52);
    dir("add_ovf", 32'h7ff00000, 32'h00100000, 2'b00, OVF_ADD_RES, 1'b1, 1'b0, 1);

    // Back-pressure: result held for 5 cycles with in_ready low.
    out_ready = 1'b0;
    run_op(32'h7ff00000, 32'h00100000, 2'b00, lat);
    chk("bp.latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.result", result, OVF_ADD_RES);
      chk("bp.ovf", ovf, 1'b1);
      chk("bp.dz", dz, 1'b0);
      chk("bp.in_ready", in_ready, 1'b0);
      chk("bp.out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.out_valid_clr", out_valid, 1'b0);
    chk("bp.in_ready_set", in_ready, 1'b1);

    dir("div_zero", 32'h00100000, 32'h00000000, 2'b11, DZ_POS_RES, 1'b0, 1'b1, 1);
    chk("dz_held_idle", dz, 1'b1);

    // Start a divide, confirm flags clear on accept, then reset in its 10th cycle.
    @(negedge clk);
    a = 32'h00300000; b = 32'h00200000; op = 2'b11; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("dz_clr_on_accept", dz, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_div_rst.out_valid", out_valid, 1'b0);
    chk("mid_div_rst.in_ready", in_ready, 1'b1);
    chk("mid_div_rst.result", result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dir("add_after_rst", 32'h00180000, 32'h00080000, 2'b00, 32'h00200000, 1'b0, 1'b0, 1);

    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      rb = $urandom;
      rop = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        ra = $signed(ra) >>> 8;
        rb = $signed(rb) >>> 8;
      end else if (mode == 2) begin
        rb = 32'h0;
      end else if (mode == 3) begin
        ra = $signed(ra) >>> 12;
        rb = $signed(rb) >>> 4;
      end
      model(ra, rb, rop, er, eo, ed);
      chk("rnd.in_ready", in_ready, 1'b1);
      run_op(ra, rb, rop, lat);
      chk("rnd.latency", lat, (rop == 2'b11 && rb != 0) ? 52 : 1);
      chk("rnd.result", result, er);
      chk("rnd.ovf", ovf, eo);
      chk("rnd.dz", dz, ed);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
